// File: rtl/gen_vga_timing.sv
// gen_vga_timing: parametrised raster generator. Produces hsync/vsync/href/data for any
// timing set, drives frame-buffer read address/enable, and absorbs a PIX_LAT-clock RAM
// read latency. A request launched on one clock edge has its frame_pixel sampled
// PIX_LAT edges later. Modes 1..3 substitute built-in test patterns for RAM data.
module gen_vga_timing #(
  parameter int unsigned   DW      = 9,
  parameter int unsigned   AW      = 19,
  parameter int unsigned   H_ACT   = 720,
  parameter int unsigned   H_FP    = 16,
  parameter int unsigned   H_SYNC  = 62,
  parameter int unsigned   H_BP    = 60,
  parameter int unsigned   V_ACT   = 480,
  parameter int unsigned   V_FP    = 9,
  parameter int unsigned   V_SYNC  = 6,
  parameter int unsigned   V_BP    = 30,
  parameter bit            HS_POL  = 1'b0,
  parameter bit            VS_POL  = 1'b0,
  parameter int unsigned   PIX_LAT = 1,
  parameter logic [DW-1:0] FILL    = '0
) (
  input  logic          clk27,
  input  logic          reset_n,
  input  logic [1:0]    mode,
  output logic [AW-1:0] frame_addr,
  output logic          rd_en,
  input  logic [DW-1:0] frame_pixel,
  output logic          hsync,
  output logic          vsync,
  output logic          href,
  output logic [DW-1:0] data,
  output logic          frame_start
);

  localparam int unsigned H_TOT  = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOT  = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned HW     = $clog2(H_TOT);
  localparam int unsigned VW     = $clog2(V_TOT);
  localparam int unsigned H_ACT0 = H_SYNC + H_BP;
  localparam int unsigned V_ACT0 = V_SYNC + V_BP;
  localparam int unsigned NPIX   = H_ACT * V_ACT;
  localparam int          LAT    = int'(PIX_LAT);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_en_q, rd_en_d;
  logic [31:0]   h32, v32, px, ln;
  logic          sync_h, sync_v, act, fs;
  logic [DW-1:0] pat;
  logic [DW-1:0] data_q, data_d;

  // ctl bits {frame_start, act, sync_v, sync_h}: PIX_LAT+1 stages to the outputs.
  logic [3:0]    ctl_q [LAT+1];
  // Payload {use_ram, pattern}: PIX_LAT stages so it meets frame_pixel at the data register.
  logic [DW:0]   pay_q [LAT];

  // Raster counters and raw timing decode.
  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(H_TOT - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VW'(V_TOT - 1)) ? '0 : vcnt_q + VW'(1);
    end
    h32    = 32'(hcnt_q);
    v32    = 32'(vcnt_q);
    px     = h32 - H_ACT0;
    ln     = v32 - V_ACT0;
    sync_h = h32 < H_SYNC;
    sync_v = v32 < V_SYNC;
    act    = (h32 >= H_ACT0) && (h32 < H_ACT0 + H_ACT) &&
             (v32 >= V_ACT0) && (v32 < V_ACT0 + V_ACT);
    fs     = (hcnt_q == '0) && (vcnt_q == '0);
  end

  // Stage A next state: mode latch at frame start, read request and row-major address.
  always_comb begin
    mode_d  = fs ? mode : mode_q;
    rd_en_d = act && (mode_q == 2'd0);
    addr_d  = addr_q;
    if (fs) begin
      addr_d = '0;
    end else if (rd_en_q) begin
      // Wrap after the last pixel so the address never leaves the frame buffer.
      addr_d = (addr_q == AW'(NPIX - 1)) ? '0 : addr_q + AW'(1);
    end
  end

  // Test-pattern value for the pixel decoded this cycle.
  always_comb begin
    pat = '0;
    case (mode_q)
      2'd1:    pat = DW'(((px * 32'd8) / H_ACT) << (DW - 3));
      2'd2:    pat = FILL;
      2'd3:    pat = ((((px ^ ln) >> 3) & 32'd1) != 32'd0) ? '1 : '0;
      default: pat = '0;
    endcase
  end

  // Counters and stage A registers.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      mode_q  <= 2'd0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
    end
  end

  // Output alignment pipeline for timing controls and pattern payload.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= LAT; i++) ctl_q[i] <= '0;
      for (int i = 0; i < LAT; i++)  pay_q[i] <= '0;
    end else begin
      ctl_q[0] <= {fs, act, sync_v, sync_h};
      for (int i = 1; i <= LAT; i++) ctl_q[i] <= ctl_q[i-1];
      pay_q[0] <= {mode_q == 2'd0, pat};
      for (int i = 1; i < LAT; i++)  pay_q[i] <= pay_q[i-1];
    end
  end

  // Data select: RAM data or pattern for an active pixel, zero otherwise.
  always_comb begin
    data_d = '0;
    if (ctl_q[LAT-1][2]) begin
      data_d = pay_q[LAT-1][DW] ? frame_pixel : pay_q[LAT-1][DW-1:0];
    end
  end

  // Data output register, aligned with the last control stage.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign frame_addr  = addr_q;
  assign rd_en       = rd_en_q;
  assign hsync       = ctl_q[LAT][0] ? HS_POL : ~HS_POL;
  assign vsync       = ctl_q[LAT][1] ? VS_POL : ~VS_POL;
  assign href        = ctl_q[LAT][2];
  assign frame_start = ctl_q[LAT][3];
  assign data        = data_q;

endmodule
